// File: rtl/packet_gen.sv
// packet_gen: builds header + payload word streams from metadata requests
// and pushes them to the crossbar under ready/enable flow control.
module packet_gen #(
  parameter int META_WIDTH = 32,
  parameter int BLOCK_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [META_WIDTH-1:0] meta_in,
  input  logic                  meta_in_valid,
  output logic                  meta_in_ready,
  output logic [31:0]           egress_out,
  output logic                  egress_out_en,
  input  logic                  egress_out_ready,
  output logic                  pkt_done,
  output logic [15:0]           pkt_cnt
);
  typedef enum logic [2:0] {IDLE, LEN_DMAC, TIME, SMAC, PAYLOAD} state_t;
  state_t      st_q, st_d;
  logic [31:0] tm_q, ts_q;
  logic [1:0]  src_q, dst_q;
  logic [6:0]  blk_q, blk_in;
  logic [9:0]  wc_q, wc_d;
  logic [15:0] len, cnt_q;
  logic        h_q, h_d, arm_q, done_q, acc, xfer, last_x;
  logic        unused_meta;
  assign unused_meta   = ^meta_in;
  assign blk_in        = meta_in[27:22] == 6'd0 ? 7'd64 : {1'b0, meta_in[27:22]};
  assign len           = 16'(blk_q) * 16'(BLOCK_SIZE);
  assign meta_in_ready = st_q == IDLE && arm_q;
  assign egress_out_en = st_q != IDLE;
  assign acc           = meta_in_valid && meta_in_ready;
  assign xfer          = egress_out_en && egress_out_ready;
  assign last_x        = xfer && st_q == PAYLOAD && wc_q == 10'd1;
  assign wc_d          = acc ? {blk_in, 3'b000} : xfer ? wc_q - 10'd1 : wc_q;
  // h_q selects the first or second word of each two-word header state
  assign h_d           = xfer ? (st_q == PAYLOAD ? 1'b0 : ~h_q) : h_q;
  assign pkt_done      = done_q;
  assign pkt_cnt       = cnt_q;
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:     st_d = acc ? LEN_DMAC : IDLE;
      LEN_DMAC: st_d = xfer && h_q ? TIME : LEN_DMAC;
      TIME:     st_d = xfer && h_q ? SMAC : TIME;
      SMAC:     st_d = xfer && h_q ? PAYLOAD : SMAC;
      PAYLOAD:  st_d = last_x ? IDLE : PAYLOAD;
      default:  st_d = IDLE;
    endcase
  end
  always_comb begin
    egress_out = '0;
    case (st_q)
      LEN_DMAC: egress_out = h_q ? {30'd0, dst_q} : {len, 14'd0, dst_q};
      TIME:     egress_out = h_q ? 32'd0 : ts_q;
      SMAC:     egress_out = h_q ? {30'd0, src_q} : {30'd0, src_q};
      PAYLOAD:  egress_out = 32'hFFFF_FFFF;
      default:  egress_out = '0;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= IDLE;
      tm_q   <= '0;
      ts_q   <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      blk_q  <= '0;
      wc_q   <= '0;
      h_q    <= 1'b0;
      arm_q  <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      tm_q   <= tm_q + 32'd1;
      wc_q   <= wc_d;
      h_q    <= h_d;
      arm_q  <= 1'b1;
      done_q <= last_x;
      cnt_q  <= cnt_q + 16'(last_x);
      if (acc) begin
        ts_q  <= tm_q;
        src_q <= meta_in[31:30];
        dst_q <= meta_in[29:28];
        blk_q <= blk_in;
      end
    end
  end
endmodule

// File: tb/tb_packet_gen.sv
// tb_packet_gen: random and directed packets checked against a word-list model.
module tb_packet_gen;
  localparam int BS = 32;
  logic        clk = 1'b0, reset = 1'b0;
  logic [31:0] meta_in = '0;
  logic        meta_in_valid = 1'b0, meta_in_ready;
  logic [31:0] egress_out;
  logic        egress_out_en, egress_out_ready = 1'b0, pkt_done;
  logic [15:0] pkt_cnt;
  logic [31:0] cyc, toff = '0;
  logic [31:0] exp_q[$];
  int          errors = 0, checks = 0, exp_cnt = 0;
  packet_gen dut (
    .clk(clk), .reset(reset), .meta_in(meta_in), .meta_in_valid(meta_in_valid),
    .meta_in_ready(meta_in_ready), .egress_out(egress_out), .egress_out_en(egress_out_en),
    .egress_out_ready(egress_out_ready), .pkt_done(pkt_done), .pkt_cnt(pkt_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk or negedge reset) cyc <= !reset ? 32'd0 : cyc + 32'd1;
  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Offers m, then drains the packet; returns at the idle cycle after it.
  task automatic send(input logic [31:0] m, input logic [31:0] next_m, input int mode,
                      input bit keep, input int abort_at);
    int b, idx, held, sc, guard;
    logic [31:0] ts;
    logic [15:0] bytes;
    meta_in = m;
    meta_in_valid = 1'b1;
    guard = 0;
    while (!meta_in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_ready", 32'(meta_in_ready), 1);
    ts = cyc + toff;
    b = m[27:22] == 6'd0 ? 64 : int'(m[27:22]);
    bytes = 16'(b * BS);
    exp_q = {};
    exp_q.push_back({bytes, 14'd0, m[29:28]});
    exp_q.push_back({30'd0, m[29:28]});
    exp_q.push_back(ts);
    exp_q.push_back(32'd0);
    exp_q.push_back({30'd0, m[31:30]});
    exp_q.push_back({30'd0, m[31:30]});
    for (int k = 6; k < b * 8; k++) exp_q.push_back(32'hFFFF_FFFF);
    @(negedge clk);
    if (keep) meta_in = next_m;
    else meta_in_valid = 1'b0;
    idx = 0; held = 0; sc = 0; guard = 0;
    while (idx < exp_q.size() && guard < 3000 && idx != abort_at) begin
      egress_out_ready = mode == 1 ? ($urandom_range(0, 3) != 0) :
                         mode == 2 ? !(idx == 4 && sc < 3) : 1'b1;
      if (mode == 2 && idx == 4 && sc < 3) sc++;
      #1;
      chk("en_busy", 32'(egress_out_en), 1);
      chk("ready_busy", 32'(meta_in_ready), 0);
      chk("done_busy", 32'(pkt_done), 0);
      chk($sformatf("word%0d", idx), egress_out, exp_q[idx]);
      if (egress_out_ready) idx++;
      else held++;
      @(negedge clk);
      guard++;
    end
    if (idx == abort_at) return;
    chk("word_total", idx, exp_q.size());
    if (mode == 2) chk("held_cycles", held, 3);
    exp_cnt++;
    #1;
    chk("done_pulse", 32'(pkt_done), 1);
    chk("pkt_cnt", 32'(pkt_cnt), exp_cnt);
    chk("idle_en", 32'(egress_out_en), 0);
    chk("idle_ready", 32'(meta_in_ready), 1);
  endtask
  initial begin
    logic [31:0] m;
    #22;
    chk("rst_ready", 32'(meta_in_ready), 0);
    chk("rst_en", 32'(egress_out_en), 0);
    chk("rst_out", egress_out, 0);
    chk("rst_done", 32'(pkt_done), 0);
    chk("rst_cnt", 32'(pkt_cnt), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1 chk("ready_after_rst", 32'(meta_in_ready), 1);
    while (cyc != 32'd5) @(negedge clk);
    send(32'h6040_0000, 0, 0, 0, -1);
    send(32'h9080_0000, 0, 2, 0, -1);
    for (int i = 0; i < 6; i++) begin
      m = $urandom;
      m[27:22] = 6'($urandom_range(1, 4));
      send(m, 0, 1, 0, -1);
    end
    send(32'hE000_0000, 0, 0, 0, -1);
    send(32'h1040_0000, 32'h2080_0000, 0, 1, -1);
    send(32'h2080_0000, 0, 1, 0, -1);
    send(32'h5080_0000, 0, 0, 0, 10);
    reset = 1'b0;
    exp_cnt = 0;
    #1;
    chk("abort_en", 32'(egress_out_en), 0);
    chk("abort_out", egress_out, 0);
    chk("abort_ready", 32'(meta_in_ready), 0);
    chk("abort_done", 32'(pkt_done), 0);
    chk("abort_cnt", 32'(pkt_cnt), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1 chk("ready_after_abort", 32'(meta_in_ready), 1);
    send(32'hB0C0_0000, 0, 1, 0, -1);
    force dut.tm_q = 32'hFFFF_FFFF;
    release dut.tm_q;
    toff = 32'hFFFF_FFFF - cyc;
    send(32'h7040_0000, 0, 0, 0, -1);
    send(32'h4040_0000, 0, 0, 0, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
